// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_receiver
// Purpose  : Deframes an async serial line (start/data/parity/stop) and hands
//            data + raw parity bit to the downstream odd-parity checker.
// Revision : 1.0
// ============================================================================
module serial_frame_receiver #(
    parameter int WIDTH          = 8,
    parameter int CYCLES_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_x,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_parity,
    output logic             o_valid,
    output logic             o_frame_error,
    output logic             o_busy
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int BW = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0] c_half_bit = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_full_bit = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] c_last_bit = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             parity_q, parity_d;
    logic             ferr_q, ferr_d;
    logic             valid_q, valid_d;
    logic             sync1_q, sync2_q;
    logic             rxs;

    assign rxs = sync2_q;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            ferr_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            ferr_q   <= ferr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        parity_d = parity_q;
        ferr_d   = ferr_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cyc_d   = c_half_bit;
                end
            end
            ST_START: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cyc_d   = c_full_bit;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else begin
                    for (int k = 0; k < WIDTH; k++) begin
                        if (bit_q == BW'(k)) begin
                            shift_d[k] = rxs;
                        end
                    end
                    cyc_d = c_full_bit;
                    if (bit_q == c_last_bit) begin
                        state_d = ST_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else begin
                    par_d   = rxs;
                    cyc_d   = c_full_bit;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else begin
                    valid_d  = 1'b1;
                    data_d   = shift_q;
                    parity_d = par_q;
                    ferr_d   = !rxs;
                    state_d  = rxs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Line stuck low after a bad stop: wait for idle before re-arming
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data        = data_q;
    assign o_parity      = parity_q;
    assign o_valid       = valid_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_receiver
// Purpose  : Scoreboard bench for serial_frame_receiver (8 data bits, 16x).
// Revision : 1.0
// ============================================================================
module tb_serial_frame_receiver;

    localparam int WIDTH = 8;
    localparam int CPB   = 16;

    logic             clk;
    logic             rst_x;
    logic             i_rx;
    logic [WIDTH-1:0] o_data;
    logic             o_parity;
    logic             o_valid;
    logic             o_frame_error;
    logic             o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       fe;
        logic       err;
        int         t;
    } exp_t;

    exp_t sb[$];

    serial_frame_receiver #(
        .WIDTH         (WIDTH),
        .CYCLES_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst_x        (rst_x),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_parity     (o_parity),
        .o_valid      (o_valid),
        .o_frame_error(o_frame_error),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Called at a negedge; the strobe lands 171 edges after the start bit is driven
    task automatic send(input logic [7:0] d, input logic p, input logic s,
                        input logic [7:0] ed, input logic ep, input logic efe, input logic eerr);
        logic [10:0] bits;
        exp_t e;
        bits = {s, p, d, 1'b0};
        e.d = ed; e.p = ep; e.fe = efe; e.err = eerr; e.t = edge_cnt + 171;
        sb.push_back(e);
        for (int b = 0; b < 11; b++) begin
            i_rx = bits[b];
            repeat (CPB) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_x && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data",         {24'd0, o_data}, {24'd0, e.d});
                check("parity",       {31'd0, o_parity}, {31'd0, e.p});
                check("frame_error",  {31'd0, o_frame_error}, {31'd0, e.fe});
                check("checker_err",  {31'd0, ~^{o_data, o_parity}}, {31'd0, e.err});
                check("strobe_cycle", edge_cnt, e.t);
            end
        end
    end

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        rst_x = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  {24'd0, o_data}, 32'd0);
        check("rst_busy",  {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        rst_x = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", {31'd0, o_busy}, 32'd0);

        // Good frame, then parity fault passed through unchanged
        send(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        send(8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Glitch: 4-cycle low pulse is a false start
        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", {31'd0, o_busy}, 32'd1);
        i_rx = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_lo", {31'd0, o_busy}, 32'd0);
        repeat (4) @(negedge clk);
        send(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Framing error with line held low afterwards
        send(8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("break_busy_hi", {31'd0, o_busy}, 32'd1);
        i_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break_busy_lo", {31'd0, o_busy}, 32'd0);

        // Back-to-back frames, no idle gap
        send(8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        send(8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_drained", sb.size(), 32'd0);

        // Reset in the middle of data bit 3 of 0x55 (LSB-first 1,0,1,0)
        i_rx = 1'b0; repeat (CPB) @(negedge clk);
        i_rx = 1'b1; repeat (CPB) @(negedge clk);
        i_rx = 1'b0; repeat (CPB) @(negedge clk);
        i_rx = 1'b1; repeat (CPB) @(negedge clk);
        i_rx = 1'b0; repeat (CPB / 2) @(negedge clk);
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        #2 rst_x = 1'b0;
        #1;
        check("async_rst_data",   {24'd0, o_data}, 32'd0);
        check("async_rst_busy",   {31'd0, o_busy}, 32'd0);
        check("async_rst_parity", {31'd0, o_parity}, 32'd0);
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_x = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        check("scoreboard_empty", sb.size(), 32'd0);
        summary();
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        summary();
        $finish;
    end

endmodule
`default_nettype wire
